fetch_unit: RTL
===============

# fetch_unit

Instruction fetch controller that sits on the control side of the program counter `pc`. It drives the PC's `ENABLE`/`MODE`/`D` inputs and consumes its `PC_OUT`. It fetches one instruction per PC value from instruction memory over a req/ack handshake and hands the instruction to decode over a valid/ready handshake. It also applies branch/jump redirects to the PC and discards any wrong-path fetch that is already in flight.

## Interface
- `RESET_ADDR`, default `32'h1A000000`: PC reset value; used as the reset value of `INSTR_PC`.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RES` input 1: reset, synchronous, active-high; shared with `pc`.
- `PC_IN` input 32: current PC, wired from `pc.PC_OUT`.
- `PC_ENABLE` output 1: to `pc.ENABLE`.
- `PC_MODE` output 1: to `pc.MODE`; 0 = +4, 1 = load `PC_D`.
- `PC_D` output 32: to `pc.D`.
- `MEM_REQ` output 1: memory read request.
- `MEM_ADDR` output 32: memory read address.
- `MEM_ACK` input 1: one-cycle pulse; `MEM_RDATA` is valid in that cycle.
- `MEM_RDATA` input 32: read data.
- `INSTR` output 32: fetched instruction.
- `INSTR_PC` output 32: address of `INSTR`.
- `INSTR_VALID` output 1: `INSTR`/`INSTR_PC` are valid.
- `INSTR_READY` input 1: decode accepts the instruction.
- `REDIRECT` input 1: one-cycle redirect request.
- `REDIRECT_ADDR` input 32: redirect target.

## Operation
- **PC contract:** on an edge with `ENABLE`=1, the PC becomes `PC_OUT+4` (`MODE`=0) or `D` (`MODE`=1). With `ENABLE`=0 it holds. `RES` sets it to `RESET_ADDR`.
- **States:**
  - IDLE: after reset. Always goes to REQ on the next edge.
  - REQ: `MEM_REQ`=1, `MEM_ADDR`=`PC_IN`. The PC is stable here because `PC_ENABLE`=0 unless there is an ack or a redirect.
    - On `MEM_ACK`: `INSTR`<=`MEM_RDATA`, `INSTR_PC`<=`PC_IN`, `INSTR_VALID`<=1, go to HOLD. In the same cycle drive `PC_ENABLE`=1, `PC_MODE`=0, so the PC advances on the capture edge.
  - HOLD: `INSTR_VALID`=1, `MEM_REQ`=0. On `INSTR_READY`: `INSTR_VALID`<=0, go to REQ.
  - DISCARD: `MEM_REQ`=1, `MEM_ADDR`=`addr_hold`. On `MEM_ACK`: drop the data and go to REQ.
- **Redirect (any state, highest priority):**
  - Same cycle: `PC_ENABLE`=1, `PC_MODE`=1, `PC_D`={`REDIRECT_ADDR`[31:2],2'b00}. The low two bits are forced to zero.
  - Next edge: `INSTR_VALID`<=0.
- **Redirect transitions by state:**
  - IDLE: go to REQ.
  - HOLD: go to REQ. A valid/ready handshake in the redirect cycle is void, and the held instruction is wrong-path.
  - REQ without `MEM_ACK`: `addr_hold`<=`PC_IN`, go to DISCARD. The request stays asserted with its original address until acked.
  - REQ with `MEM_ACK` in the same cycle: drop the data, no capture, go to REQ.
  - DISCARD: PC loads again, stay in DISCARD.
- **Non-redirect cycles:** `PC_D`=0 and `PC_MODE`=0 whenever `PC_ENABLE` is not asserted by a redirect.
- **Memory rule:** once `MEM_REQ` rises, `MEM_REQ` and `MEM_ADDR` stay constant until `MEM_ACK`. `MEM_ACK` while `MEM_REQ`=0 is ignored.

## Timing
- **Reset values:** state IDLE, `INSTR`=0, `INSTR_PC`=`RESET_ADDR`, `INSTR_VALID`=0, `MEM_REQ`=0, `MEM_ADDR`=0, `PC_ENABLE`=0, `PC_MODE`=0, `PC_D`=0.
- **Output timing:** `PC_*` outputs and `MEM_ADDR` are combinational from state and inputs. All `PC_*` outputs are forced to 0 while `RES`=1.
- **Throughput:** with memory latency L (ack L cycles after `MEM_REQ` rises, L≥0) and decode always ready, one instruction is delivered every L+2 cycles.
  - Deassertion of `RES` → first `MEM_REQ` after 1 cycle (IDLE).
  - `MEM_ACK` edge → `INSTR_VALID` high in the following cycle.
- **Redirect latency:** redirect in cycle t → `PC_IN`=target in cycle t+1, and the first target fetch request is in cycle t+1 (REQ) or after the discarded ack.
- **Reset mid-fetch:** state goes to IDLE and any outstanding memory transaction is abandoned. The memory must also be reset by `RES`.

## Test plan
- **Reset:** assert `RES` for 2 cycles → all outputs at reset values, `INSTR_PC`=`32'h1A000000`, `PC_IN`=`32'h1A000000`.
- **Two fetches, L=2:** memory returns `32'hDEADBEEF` then `32'h00000013` → `INSTR_PC`=`1A000000` then `1A000004`; `PC_IN`=`1A000008` afterwards; exactly one `PC_ENABLE` pulse per fetch.
- **Decode stall:** hold `INSTR_READY`=0 for 5 cycles → `INSTR_VALID`, `INSTR` and `PC_IN` all stable, `MEM_REQ`=0; raise `INSTR_READY` → next request 1 cycle later.
- **Redirect during REQ, L=3:** redirect to `32'h1A000100` one cycle after `MEM_REQ` rises → `MEM_ADDR` stays `1A000000` until ack, data dropped, next request has `MEM_ADDR`=`1A000100`.
- **Redirect same cycle as ack:** redirect to `32'h1A000040` → `INSTR_VALID` stays 0, next fetch is from `1A000040`.
- **Misaligned redirect in HOLD:** redirect to `32'h1A000083` → `PC_D`=`1A000080`, `INSTR_VALID` drops on the next edge, fetch from `1A000080`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_if: bundles every non-clock/reset signal of fetch_unit.
//   PC side     : PC_IN (from pc.PC_OUT), PC_ENABLE / PC_MODE / PC_D (to pc)
//   Memory side : MEM_REQ / MEM_ADDR out, MEM_ACK / MEM_RDATA in
//   Decode side : INSTR / INSTR_PC / INSTR_VALID out, INSTR_READY in
//   Redirect    : REDIRECT / REDIRECT_ADDR in
// master = fetch_unit, slave = the environment (pc, memory, decode, branch unit).
interface fetch_if;
    logic [31:0] PC_IN;
    logic        PC_ENABLE;
    logic        PC_MODE;
    logic [31:0] PC_D;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        REDIRECT;
    logic [31:0] REDIRECT_ADDR;

    modport master (
        input  PC_IN, MEM_ACK, MEM_RDATA, INSTR_READY, REDIRECT, REDIRECT_ADDR,
        output PC_ENABLE, PC_MODE, PC_D, MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID
    );

    modport slave (
        output PC_IN, MEM_ACK, MEM_RDATA, INSTR_READY, REDIRECT, REDIRECT_ADDR,
        input  PC_ENABLE, PC_MODE, PC_D, MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch controller driving an external program counter.
//   CLK, RES     : clock, synchronous active-high reset (shared with pc)
//   bus (master) : PC control, memory req/ack port, decode valid/ready port,
//                  redirect request (see fetch_if)
//   dbg_state_o  : current FSM state, for observation only
//
// Handshakes:
//   Memory: MEM_REQ/MEM_ADDR stay constant from the rising of MEM_REQ until the
//   single-cycle MEM_ACK pulse; MEM_RDATA is only meaningful in the ack cycle and
//   an ack while MEM_REQ=0 has no effect.
//   Decode: an instruction transfers on a cycle with INSTR_VALID=1 and
//   INSTR_READY=1; INSTR/INSTR_PC hold steady while INSTR_VALID=1 and not taken.
//   A redirect cycle voids any transfer in that same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h1A000000
) (
    input  logic       CLK,
    input  logic       RES,
    fetch_if.master    bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    // Address of a request that was in flight when a redirect arrived; the
    // memory still owes us an ack for it, so it is presented until then.
    logic [31:0] addr_hold_q;

    logic        redirect_act;

    assign redirect_act = bus.REDIRECT && !RES;

    // PC control: redirect loads the aligned target; otherwise the PC only
    // advances on the edge that captures a fetched instruction.
    always_comb begin
        bus.PC_ENABLE = 1'b0;
        bus.PC_MODE   = 1'b0;
        bus.PC_D      = 32'h0;
        if (redirect_act) begin
            bus.PC_ENABLE = 1'b1;
            bus.PC_MODE   = 1'b1;
            bus.PC_D      = {bus.REDIRECT_ADDR[31:2], 2'b00};
        end else if (!RES && (state_q == S_REQ) && bus.MEM_ACK) begin
            bus.PC_ENABLE = 1'b1;
        end
    end

    always_comb begin
        bus.MEM_REQ  = 1'b0;
        bus.MEM_ADDR = 32'h0;
        case (state_q)
            S_REQ: begin
                bus.MEM_REQ  = 1'b1;
                bus.MEM_ADDR = bus.PC_IN;
            end
            S_DISCARD: begin
                bus.MEM_REQ  = 1'b1;
                bus.MEM_ADDR = addr_hold_q;
            end
            default: begin
                bus.MEM_REQ  = 1'b0;
                bus.MEM_ADDR = 32'h0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q       <= S_IDLE;
            instr_q       <= 32'h0;
            instr_pc_q    <= RESET_ADDR;
            instr_valid_q <= 1'b0;
            addr_hold_q   <= 32'h0;
        end else if (bus.REDIRECT) begin
            // Whatever is held or arriving now is wrong-path.
            instr_valid_q <= 1'b0;
            case (state_q)
                S_REQ: begin
                    if (bus.MEM_ACK) begin
                        state_q <= S_REQ;
                    end else begin
                        addr_hold_q <= bus.PC_IN;
                        state_q     <= S_DISCARD;
                    end
                end
                S_DISCARD: state_q <= S_DISCARD;
                default:   state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (bus.MEM_ACK) begin
                        instr_q       <= bus.MEM_RDATA;
                        instr_pc_q    <= bus.PC_IN;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.INSTR_READY) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (bus.MEM_ACK) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.INSTR       = instr_q;
    assign bus.INSTR_PC    = instr_pc_q;
    assign bus.INSTR_VALID = instr_valid_q;
    assign dbg_state_o     = state_q;
endmodule
